// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0, MSB first, for the SD card port pair (cs latch + data exchange).
// Latency: busy for 16*DIV ce pulses after the start edge; q updates on the edge busy falls.
// Backpressure: wr/rd strobes seen while busy are dropped; csWr is honoured in any state.
module spi_master #(
  parameter int         DIV  = 1,
  parameter logic [7:0] IDLE = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       csWr,
  input  logic       csD,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       busy,
  output logic       cs,
  output logic       ck,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] sr, sr_nxt;
  logic [7:0] q_nxt;
  logic [7:0] div_cnt, div_nxt;
  logic [3:0] hb, hb_nxt;
  logic       sb, sb_nxt;
  logic       ck_nxt, mosi_nxt, cs_nxt;
  logic [7:0] load_byte;

  // wr takes priority over rd when both strobe together
  assign load_byte = wr ? d : IDLE;
  assign busy      = (state == ST_SHIFT);

  // State register; reset aborts any exchange immediately
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers: shifter, sample bit, counters and pin drivers
  always_ff @(posedge clock) begin
    if (reset) begin
      sr      <= 8'hFF;
      q       <= 8'hFF;
      div_cnt <= 8'd0;
      hb      <= 4'd0;
      sb      <= 1'b1;
      ck      <= 1'b0;
      mosi    <= 1'b1;
      cs      <= 1'b1;
    end else begin
      sr      <= sr_nxt;
      q       <= q_nxt;
      div_cnt <= div_nxt;
      hb      <= hb_nxt;
      sb      <= sb_nxt;
      ck      <= ck_nxt;
      mosi    <= mosi_nxt;
      cs      <= cs_nxt;
    end
  end

  // Next-state: start on a strobe in IDLE, then one half-bit per DIV ce pulses
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    q_nxt     = q;
    div_nxt   = div_cnt;
    hb_nxt    = hb;
    sb_nxt    = sb;
    ck_nxt    = ck;
    mosi_nxt  = mosi;
    // cs is independent of the exchange; the byte finishes on the wire regardless
    cs_nxt    = csWr ? csD : cs;

    case (state)
      ST_IDLE: begin
        if (wr || rd) begin
          sr_nxt    = load_byte;
          hb_nxt    = 4'd0;
          div_nxt   = 8'd0;
          mosi_nxt  = load_byte[7];
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ce) begin
          if (div_cnt == DIV_LAST) begin
            div_nxt = 8'd0;
            if (!hb[0]) begin
              // leading edge: card samples mosi, we sample miso
              ck_nxt = 1'b1;
              sb_nxt = miso;
            end else begin
              // trailing edge: shift sample in and present the next MSB
              ck_nxt   = 1'b0;
              sr_nxt   = {sr[6:0], sb};
              mosi_nxt = sr[6];
              if (hb == 4'd15) begin
                q_nxt     = {sr[6:0], sb};
                mosi_nxt  = 1'b1;
                state_nxt = ST_IDLE;
              end
            end
            // hb saturates at 15; the exchange ends there
            if (hb != 4'd15) hb_nxt = hb + 4'd1;
          end else begin
            div_nxt = div_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: DIV=1 instance driven from a vector table, DIV=3 instance
// exercised by hand for phase timing and ce freeze, plus mid-byte strobe and reset abort.
// Expected bytes, pulse counts and ce counts are hand-computed constants in the table.
module tb_spi_master;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, ce_en, csWr, csD, wr, rd, wr3;
  logic [7:0] d;
  logic       ce = 1'b0;
  int         cediv = 0;

  logic [7:0] q1, q3;
  logic       busy1, cs1, ck1, mosi1;
  logic       busy3, cs3, ck3, mosi3;

  // card model: presents MSB first, advances on each falling ck
  logic       loop1;
  logic [7:0] card_byte;
  int         card_idx = 0;
  int         card_base;
  wire        miso1 = loop1 ? mosi1 : card_byte[3'(7 - (card_idx - card_base))];

  int         ck_cnt1 = 0, ck_cnt3 = 0;
  logic [7:0] rx1 = 8'h00, rx3 = 8'h00;

  int checks = 0;
  int errors = 0;

  spi_master #(.DIV(1), .IDLE(8'hFF)) u_dut1 (
    .clock(clock), .reset(reset), .ce(ce), .csWr(csWr), .csD(csD),
    .wr(wr), .rd(rd), .d(d), .q(q1), .busy(busy1), .cs(cs1),
    .ck(ck1), .mosi(mosi1), .miso(miso1)
  );

  spi_master #(.DIV(3), .IDLE(8'hFF)) u_dut3 (
    .clock(clock), .reset(reset), .ce(ce), .csWr(csWr), .csD(csD),
    .wr(wr3), .rd(1'b0), .d(d), .q(q3), .busy(busy3), .cs(cs3),
    .ck(ck3), .mosi(mosi3), .miso(mosi3)
  );

  // ce: one clock wide, every 4th clock, changed just after the active edge
  always @(posedge clock) begin
    #1;
    cediv <= (cediv + 1) % 4;
    ce    <= ce_en && (((cediv + 1) % 4) == 0);
  end

  // wire monitors: count ck pulses and capture mosi at each rising ck
  always @(posedge ck1) begin
    ck_cnt1 <= ck_cnt1 + 1;
    rx1     <= {rx1[6:0], mosi1};
  end
  always @(posedge ck3) begin
    ck_cnt3 <= ck_cnt3 + 1;
    rx3     <= {rx3[6:0], mosi3};
  end
  always @(negedge ck1) card_idx <= card_idx + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] dv;
    logic       loop;
    logic [7:0] card;
    logic [7:0] exp_mosi;
    logic [7:0] exp_qmid;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[4];

  // one full exchange on the DIV=1 instance, checked against a table row
  task automatic run_row(input vec_t v, input string tag);
    int base_ck, ce_n, qbad, guard;
    @(negedge clock);
    loop1     = v.loop;
    card_byte = v.card;
    card_base = card_idx;
    base_ck   = ck_cnt1;
    wr = v.w; rd = v.r; d = v.dv;
    @(negedge clock);
    wr = 1'b0; rd = 1'b0;
    check({tag, "_busy_start"}, 32'(busy1), 32'd1);
    ce_n = 0; qbad = 0; guard = 0;
    while (busy1 && guard < 2000) begin
      if (ce) ce_n++;
      if (q1 !== v.exp_qmid) qbad++;
      @(negedge clock);
      guard++;
    end
    check({tag, "_timeout"},  32'(guard < 2000), 32'd1);
    check({tag, "_busy_ce"},  32'(ce_n), 32'd16);
    check({tag, "_ck_pulses"}, 32'(ck_cnt1 - base_ck), 32'd8);
    check({tag, "_mosi_bits"}, 32'(rx1), 32'(v.exp_mosi));
    check({tag, "_q_during"}, 32'(qbad), 32'd0);
    check({tag, "_q_after"},  32'(q1), 32'(v.exp_q));
    check({tag, "_idle_pins"}, {30'd0, mosi1, ck1}, 32'd2);
  endtask

  initial begin
    int   base_ck, guard, ce_n, phase, bad, changes;
    logic prev_ck, froze;
    logic [10:0] snap;
    vec_t abort_vec;

    tbl[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 8'h00, 8'hA5, 8'hFF, 8'hA5};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h3C, 8'hFF, 8'hA5, 8'h3C};
    tbl[2] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h5A, 8'h00, 8'h3C, 8'h5A};
    tbl[3] = '{1'b1, 1'b0, 8'hC3, 1'b1, 8'h00, 8'hC3, 8'h5A, 8'hC3};

    reset = 1'b1; ce_en = 1'b1; csWr = 1'b0; csD = 1'b1;
    wr = 1'b0; rd = 1'b0; wr3 = 1'b0; d = 8'h00;
    loop1 = 1'b1; card_byte = 8'hFF; card_base = 0;

    // reset state
    repeat (2) @(negedge clock);
    check("rst_pins1", {27'd0, cs1, ck1, mosi1, busy1, 1'b0}, {27'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    check("rst_q1", 32'(q1), 32'hFF);
    check("rst_pins3", {28'd0, cs3, ck3, mosi3, busy3}, 32'b1010);
    check("rst_q3", 32'(q3), 32'hFF);
    reset = 1'b0;

    // cs latch
    csWr = 1'b1; csD = 1'b0;
    @(negedge clock);
    csWr = 1'b0;
    check("cs_select", 32'(cs1), 32'd0);

    for (int i = 0; i < 4; i++) run_row(tbl[i], $sformatf("row%0d", i));

    // second wr mid-byte is dropped; cs may change while busy
    @(negedge clock);
    loop1 = 1'b1; base_ck = ck_cnt1;
    wr = 1'b1; d = 8'h81;
    @(negedge clock);
    wr = 1'b0;
    repeat (20) @(negedge clock);
    check("mid_busy", 32'(busy1), 32'd1);
    wr = 1'b1; d = 8'hFF; csWr = 1'b1; csD = 1'b1;
    @(negedge clock);
    wr = 1'b0; csWr = 1'b0;
    check("mid_cs_deassert", 32'(cs1), 32'd1);
    guard = 0;
    while (busy1 && guard < 2000) begin @(negedge clock); guard++; end
    check("mid_timeout", 32'(guard < 2000), 32'd1);
    check("mid_ck_pulses", 32'(ck_cnt1 - base_ck), 32'd8);
    check("mid_mosi_bits", 32'(rx1), 32'h81);
    check("mid_q", 32'(q1), 32'h81);
    repeat (20) @(negedge clock);
    check("mid_no_requeue", {31'd0, busy1}, 32'd0);
    check("mid_no_extra_ck", 32'(ck_cnt1 - base_ck), 32'd8);

    // DIV=3: every ck phase spans 3 ce pulses; ce frozen for 100 clocks mid-byte
    @(negedge clock);
    base_ck = ck_cnt3;
    wr3 = 1'b1; d = 8'h5A;
    @(negedge clock);
    wr3 = 1'b0;
    prev_ck = ck3; phase = 0; ce_n = 0; bad = 0; changes = 0; froze = 1'b0; guard = 0;
    while (guard < 5000) begin
      if (ck3 !== prev_ck) begin
        changes++;
        if (phase != 3) bad++;
        phase = 0;
        prev_ck = ck3;
      end
      if (!busy3) break;
      if (ce) begin phase++; ce_n++; end
      if (!froze && ce_n == 20 && !ce) begin
        snap = {ck3, mosi3, busy3, q3};
        ce_en = 1'b0;
        repeat (100) @(negedge clock);
        check("div3_frozen", 32'({ck3, mosi3, busy3, q3}), 32'(snap));
        check("div3_frozen_busy", 32'(busy3), 32'd1);
        ce_en = 1'b1;
        froze = 1'b1;
      end
      @(negedge clock);
      guard++;
    end
    check("div3_timeout", 32'(guard < 5000), 32'd1);
    check("div3_froze", 32'(froze), 32'd1);
    check("div3_phases", 32'(changes), 32'd16);
    check("div3_phase_len", 32'(bad), 32'd0);
    check("div3_busy_ce", 32'(ce_n), 32'd48);
    check("div3_ck_pulses", 32'(ck_cnt3 - base_ck), 32'd8);
    check("div3_mosi_bits", 32'(rx3), 32'h5A);
    check("div3_q", 32'(q3), 32'h5A);

    // reset while ck is high on bit 4 aborts the exchange
    @(negedge clock);
    loop1 = 1'b1; base_ck = ck_cnt1;
    wr = 1'b1; d = 8'h96;
    @(negedge clock);
    wr = 1'b0;
    guard = 0;
    while (!((ck_cnt1 - base_ck) == 5 && ck1) && guard < 2000) begin @(negedge clock); guard++; end
    check("abort_reach_bit4", 32'(guard < 2000), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_pins", {29'd0, ck1, busy1, mosi1}, 32'b001);
    check("abort_q", 32'(q1), 32'hFF);
    reset = 1'b0;
    abort_vec = '{1'b1, 1'b0, 8'h96, 1'b1, 8'h00, 8'h96, 8'hFF, 8'h96};
    run_row(abort_vec, "post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
